memory_port_arbiter: RTL
========================

Name: memory_port_arbiter

Overview:
- Shares the single word-addressed 17-bit main memory port between the CPU (port 0) and the I/O processor (port 1).
- Arbitrates pending requests and issues one access at a time to memory with a fixed read latency.
- Returns read data and a completion pulse to the winning requester.
- Sits between the CPU's memory interface (lb address, c-register data input) and the memory array.

Parameters:
- MEM_LATENCY, 2, cycles from the mem_req cycle to the cycle mem_rdata is valid (legal range 1..15).
- STARVE_LIMIT, 3, consecutive IOP grants allowed while the CPU waits before the CPU is forced to win (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the clock edge; 0 = reset).
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  17  word address [15:31].
- cpu_wdata  in  32  write data [0:31].
- cpu_gnt  out  1  one-cycle grant pulse.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid while cpu_done=1 and held afterwards.
- iop_req, iop_we, iop_addr, iop_wdata, iop_gnt, iop_done, iop_rdata: same as the CPU set, for the IOP.
- mem_req  out  1  one-cycle memory strobe.
- mem_we  out  1  write enable qualifying mem_req.
- mem_addr  out  17  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid exactly MEM_LATENCY cycles after mem_req.
- busy  out  1  1 from the grant cycle through the done cycle.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; all outputs 0 (gnt, done, rdata, mem_*, busy); streak counter 0. Reset mid-access aborts the access: no done pulse is issued, and the late mem_rdata is ignored.
- States: IDLE -> ACCESS -> RETURN -> IDLE.
- IDLE:
  - Arbitrate the request inputs sampled this cycle.
  - If any request is present: latch the winner's we/addr/wdata, go to ACCESS, load the latency counter with MEM_LATENCY.
- Arbitration:
  - Only IOP requesting: IOP wins. Only CPU requesting: CPU wins.
  - Both requesting: IOP wins unless streak == STARVE_LIMIT, in which case CPU wins.
- streak counter (4 bits):
  - +1 on each IOP grant made while cpu_req=1, saturating at STARVE_LIMIT.
  - Cleared on any CPU grant.
  - Cleared in any IDLE cycle with cpu_req=0.
- First ACCESS cycle:
  - Winner's gnt=1 and mem_req=1 for exactly this cycle; mem_we/mem_addr/mem_wdata driven from the latched values. busy=1.
  - The counter decrements each cycle.
  - When it reaches 0, mem_rdata is valid: if the access is a read, capture it into the winner's rdata register. Go to RETURN.
- RETURN:
  - Winner's done=1 for one cycle; rdata is updated only for reads.
  - busy=0 next cycle; go to IDLE.
- Latency: request sampled in IDLE at cycle 0 -> gnt/mem_req at cycle 1 -> mem_rdata at cycle 1+MEM_LATENCY -> done at cycle 2+MEM_LATENCY -> earliest next mem_req at cycle 4+MEM_LATENCY.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Dropping req before gnt withdraws the request.
  - req still high in the IDLE cycle after done counts as a new request.
  - req changes during ACCESS/RETURN are ignored.
- mem_addr, mem_we and mem_wdata hold their last values when mem_req=0. A requester's rdata holds until its next read completes.
- gnt and done are never asserted to both ports in the same cycle.

Optional Feature:
- Macro MEM_PROTECT_EN.
- When defined:
  - Adds input protect_base (17 bits) and output cpu_fault (1 bit, reset 0).
  - A CPU write with cpu_addr < protect_base is granted normally, but mem_req stays 0 (memory is never touched).
  - cpu_done pulses on the normal schedule; cpu_fault=1 in the same cycle as cpu_done.
  - IOP writes and all reads are unaffected.
- When undefined: no extra ports, and all writes reach memory.

Test Plan:
- Reset=0 for 2 cycles while cpu_req=1 -> all outputs 0, no mem_req; after reset=1, CPU read of addr 0x00010 with MEM_LATENCY=2 -> cpu_gnt/mem_req at cycle 1, cpu_done at cycle 4 with cpu_rdata = memory[0x10].
- CPU write 0xDEADBEEF to 0x1FFFF, then read it back -> mem_we=1 only on the write strobe; the read returns 0xDEADBEEF; cpu_rdata is unchanged by the write's done pulse.
- cpu_req and iop_req asserted together in one IDLE cycle -> iop_gnt first; cpu_gnt follows after iop_done.
- Both held high continuously, STARVE_LIMIT=3 -> grant order I,I,I,C,I,I,I,C; streak returns to 0 after each CPU grant.
- Reset=0 pulsed in the ACCESS cycle of an IOP read -> no iop_done; the stale mem_rdata is ignored; the next request is granted normally.
- MEM_PROTECT_EN, protect_base=0x00100: CPU write to 0x000FF -> no mem_req, cpu_fault and cpu_done together; write to 0x00100 -> mem_req=1, cpu_fault=0.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares the single word-addressed 17-bit main memory port between the CPU
// (port 0) and the I/O processor (port 1). One access is in flight at a time.
// Each access runs IDLE -> ACCESS -> RETURN -> IDLE.
// The IOP wins ties, except that the CPU is forced through once the IOP has won
// STARVE_LIMIT consecutive grants while the CPU was waiting.
// Optional build macro: MEM_PROTECT_EN adds the protect_base input and the
// cpu_fault output. CPU writes below protect_base are then suppressed and flagged.
module memory_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [16:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   input  logic        iop_req,
   input  logic        iop_we,
   input  logic [16:0] iop_addr,
   input  logic [31:0] iop_wdata,
   output logic        iop_gnt,
   output logic        iop_done,
   output logic [31:0] iop_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [16:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef MEM_PROTECT_EN
   ,
   input  logic [16:0] protect_base,
   output logic        cpu_fault
`endif
);

   localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RETURN} state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] lat_cnt;
   logic [3:0] streak;
   logic       owner_iop;
   logic       acc_we;
   logic       acc_fault;
   logic       any_req;
   logic       pick_iop;
   logic       grant_fault;
   logic       first_cycle;

   // Pick the winner among this cycle's requests; flag CPU writes into the protected region
   always_comb begin
      any_req     = cpu_req | iop_req;
      pick_iop    = iop_req & ~(cpu_req & (streak == STARVE_MAX));
      grant_fault = 1'b0;
`ifdef MEM_PROTECT_EN
      grant_fault = ~pick_iop & cpu_req & cpu_we & (cpu_addr < protect_base);
`endif
   end

   // State register; a reset in mid-access drops straight back to IDLE
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the handshake pulses decoded from state and the latched owner
   always_comb begin
      state_next  = state;
      first_cycle = (state == ACCESS) && (lat_cnt == LAT_INIT);
      case (state)
         IDLE:    if (any_req) state_next = ACCESS;
         ACCESS:  if (lat_cnt == 4'd0) state_next = RETURN;
         RETURN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      cpu_gnt  = first_cycle & ~owner_iop;
      iop_gnt  = first_cycle & owner_iop;
      mem_req  = first_cycle & ~acc_fault;
      cpu_done = (state == RETURN) & ~owner_iop;
      iop_done = (state == RETURN) & owner_iop;
      busy     = (state != IDLE);
`ifdef MEM_PROTECT_EN
      cpu_fault = (state == RETURN) & ~owner_iop & acc_fault;
`endif
   end

   // Latch the winning request, count down the memory latency, and capture read data
   always_ff @(posedge clock) begin
      if (!reset) begin
         lat_cnt   <= 4'd0;
         owner_iop <= 1'b0;
         acc_we    <= 1'b0;
         acc_fault <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 17'd0;
         mem_wdata <= 32'd0;
         cpu_rdata <= 32'd0;
         iop_rdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_iop <= pick_iop;
                  lat_cnt   <= LAT_INIT;
                  acc_we    <= pick_iop ? iop_we : cpu_we;
                  acc_fault <= grant_fault;
                  if (!grant_fault) begin
                     mem_we    <= pick_iop ? iop_we    : cpu_we;
                     mem_addr  <= pick_iop ? iop_addr  : cpu_addr;
                     mem_wdata <= pick_iop ? iop_wdata : cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               if (lat_cnt == 4'd0) begin
                  if (!acc_we) begin
                     if (owner_iop) begin
                        iop_rdata <= mem_rdata;
                     end else begin
                        cpu_rdata <= mem_rdata;
                     end
                  end
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Starvation streak: consecutive IOP wins taken while the CPU was also asking
   always_ff @(posedge clock) begin
      if (!reset) begin
         streak <= 4'd0;
      end else if (state == IDLE) begin
         if (!cpu_req) begin
            streak <= 4'd0;
         end else if (pick_iop) begin
            if (streak < STARVE_MAX) streak <= streak + 4'd1;
         end else begin
            streak <= 4'd0;
         end
      end
   end

endmodule
